// File: rtl/harvos_mpu_pkg.sv
// Shared types for the MPU region checker: request/cause encodings,
// permission bit positions and the per-slot region record.
package harvos_mpu_pkg;

    typedef enum logic [1:0] {
        CHK_FETCH = 2'd0,
        CHK_LOAD  = 2'd1,
        CHK_STORE = 2'd2,
        CHK_RSVD  = 2'd3
    } chk_type_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_NOMATCH = 2'd1,
        CAUSE_PERM    = 2'd2,
        CAUSE_PRIV    = 2'd3
    } cause_e;

    localparam int PERM_R = 0;
    localparam int PERM_W = 1;
    localparam int PERM_X = 2;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] limit;
        logic [2:0]  perm;
        logic        user_ok;
        logic        is_ispace;
    } region_t;

endpackage

// File: rtl/mpu_region_match.sv
// Combinational evaluation of one region slot against a check request:
// address/space match, access-type permission and privilege flags.
module mpu_region_match
    import harvos_mpu_pkg::*;
(
    input  region_t     region,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [1:0]  chk_type,
    input  logic        user,
    output logic        match,
    output logic        perm_ok,
    output logic        priv_ok
);

    // Match, permission and privilege flags for this slot.
    always_comb begin
        match   = valid
                  && (addr >= region.base)
                  && (addr <= region.limit)
                  && (region.is_ispace == (chk_type == CHK_FETCH));
        priv_ok = !user || region.user_ok;
        case (chk_type)
            CHK_FETCH: perm_ok = region.perm[PERM_X];
            CHK_LOAD:  perm_ok = region.perm[PERM_R];
            CHK_STORE: perm_ok = region.perm[PERM_W];
            default:   perm_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mpu_region_checker.sv
// MPU region checker: a lockable table of NREG regions, and a one-cycle
// latency check pipeline with valid/ready handshakes and a deny counter.
module mpu_region_checker
    import harvos_mpu_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prog_en,
    input  logic [2:0]      prog_idx,
    input  logic [31:0]     prog_base,
    input  logic [31:0]     prog_limit,
    input  logic [2:0]      prog_perm,
    input  logic            prog_user_ok,
    input  logic            prog_is_ispace,
    input  logic            lock_set,
    output logic            locked,
    output logic            prog_reject,
    output logic [NREG-1:0] region_valid,
    input  logic            chk_valid,
    output logic            chk_ready,
    input  logic [31:0]     chk_addr,
    input  logic [1:0]      chk_type,
    input  logic            chk_user,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_allow,
    output logic            rsp_hit,
    output logic [2:0]      rsp_region,
    output logic [1:0]      rsp_cause,
    output logic [15:0]     fault_cnt
);

    region_t regions [NREG];

    logic [NREG-1:0] slot_match;
    logic [NREG-1:0] slot_perm_ok;
    logic [NREG-1:0] slot_priv_ok;

    logic        write_accept;
    logic        chk_fire;
    logic        hit;
    logic [2:0]  hit_idx;
    logic        hit_perm_ok;
    logic        hit_priv_ok;
    logic        next_allow;
    cause_e      next_cause;

    assign chk_ready = !rsp_valid || rsp_ready;
    assign chk_fire  = chk_valid && chk_ready;

    // Lock has priority over a write in the same cycle; W+X together is illegal.
    always_comb begin
        write_accept = prog_en
                       && !locked
                       && !lock_set
                       && ({29'd0, prog_idx} < 32'(NREG))
                       && (prog_base <= prog_limit)
                       && !(prog_perm[PERM_X] && prog_perm[PERM_W]);
    end

    for (genvar g = 0; g < NREG; g++) begin : g_slot
        mpu_region_match u_match (
            .region   (regions[g]),
            .valid    (region_valid[g]),
            .addr     (chk_addr),
            .chk_type (chk_type),
            .user     (chk_user),
            .match    (slot_match[g]),
            .perm_ok  (slot_perm_ok[g]),
            .priv_ok  (slot_priv_ok[g])
        );
    end

    // Lowest-index matching slot wins; scanning downward leaves it last.
    always_comb begin
        hit         = 1'b0;
        hit_idx     = 3'd0;
        hit_perm_ok = 1'b0;
        hit_priv_ok = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (slot_match[i]) begin
                hit         = 1'b1;
                hit_idx     = 3'(i);
                hit_perm_ok = slot_perm_ok[i];
                hit_priv_ok = slot_priv_ok[i];
            end
        end
    end

    // Verdict: reserved type always denied, then no-match, privilege, permission.
    always_comb begin
        next_allow = 1'b0;
        next_cause = CAUSE_NONE;
        if (chk_type == CHK_RSVD) begin
            next_cause = CAUSE_PERM;
        end else if (!hit) begin
            next_cause = CAUSE_NOMATCH;
        end else if (!hit_priv_ok) begin
            next_cause = CAUSE_PRIV;
        end else if (!hit_perm_ok) begin
            next_cause = CAUSE_PERM;
        end else begin
            next_allow = 1'b1;
        end
    end

    // Region table, valid bits, lock flag and reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regions[i] <= '0;
            end
            region_valid <= '0;
            locked       <= 1'b0;
            prog_reject  <= 1'b0;
        end else begin
            prog_reject <= prog_en && !write_accept;
            if (lock_set) begin
                locked <= 1'b1;
            end
            for (int i = 0; i < NREG; i++) begin
                if (write_accept && ({29'd0, prog_idx} == 32'(i))) begin
                    regions[i].base      <= prog_base;
                    regions[i].limit     <= prog_limit;
                    regions[i].perm      <= prog_perm;
                    regions[i].user_ok   <= prog_user_ok;
                    regions[i].is_ispace <= prog_is_ispace;
                    region_valid[i]      <= 1'b1;
                end
            end
        end
    end

    // Response register: loads on accept, holds while stalled downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_allow  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_region <= 3'd0;
            rsp_cause  <= CAUSE_NONE;
        end else begin
            if (chk_ready) begin
                rsp_valid <= chk_valid;
            end
            if (chk_fire) begin
                rsp_allow  <= next_allow;
                rsp_hit    <= hit;
                rsp_region <= hit ? hit_idx : 3'd0;
                rsp_cause  <= next_cause;
            end
        end
    end

    // Saturating count of denied responses as they are handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt <= 16'd0;
        end else if (rsp_valid && rsp_ready && !rsp_allow && (fault_cnt != 16'hFFFF)) begin
            fault_cnt <= fault_cnt + 16'd1;
        end
    end

endmodule

// File: doc/mpu_region_checker.md
MPU_REGION_CHECKER -- requirements
Module: mpu_region_checker

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning number of region slots (2..8).
REQ-002 SHALL have ports clk input 1 (sole clock) and rst_n input 1 (reset); reset SHALL be asynchronous and active-low.
REQ-003 SHALL have prog_en in 1, write strobe for one region.
REQ-004 SHALL have prog_idx in 3, prog_base in 32, prog_limit in 32 (inclusive), prog_perm in 3 {X,W,R}, prog_user_ok in 1 and prog_is_ispace in 1, carrying the region write data.
REQ-005 SHALL have lock_set in 1, a pulse on smpuctl (0x130) bit0 write of 1.
REQ-006 SHALL have locked out 1, indicating the table is immutable.
REQ-007 SHALL have prog_reject out 1, a one-cycle pulse when a write is refused.
REQ-008 SHALL have region_valid out NREG, the per-slot valid bits.
REQ-009 SHALL have chk_valid in 1 and chk_ready out 1, the request handshake.
REQ-010 SHALL have chk_addr in 32, chk_type in 2 (FETCH=0, LOAD=1, STORE=2; 3 reserved) and chk_user in 1, the request payload.
REQ-011 SHALL have rsp_valid out 1 and rsp_ready in 1, the response handshake.
REQ-012 SHALL have rsp_allow out 1, rsp_hit out 1, rsp_region out 3 (winning slot, 0 if no hit) and rsp_cause out 2 (NONE=0, NOMATCH=1, PERM=2, PRIV=3), the response payload.
REQ-013 SHALL have fault_cnt out 16, a saturating deny counter.

Function
REQ-014 A write SHALL be accepted on prog_en when not locked, lock_set=0, prog_idx<NREG, prog_base<=prog_limit and prog_perm X&W not both set; otherwise prog_reject SHALL pulse the next cycle and the table SHALL be unchanged.
REQ-015 An accepted write SHALL update all slot fields and set region_valid[idx] at the next clk edge; rewriting a valid slot before lock SHALL overwrite it.
REQ-016 locked SHALL be set on the edge after lock_set and held until reset; lock_set while locked SHALL be a no-op.
REQ-017 lock_set together with prog_en SHALL reject the write (lock wins).
REQ-018 chk_ready SHALL equal !rsp_valid || rsp_ready.
REQ-019 A request SHALL be accepted when chk_valid && chk_ready, and its response SHALL appear with rsp_valid=1 on the next cycle (latency 1).
REQ-020 The response registers SHALL hold stable while rsp_valid && !rsp_ready; full throughput of one per cycle SHALL be sustained when rsp_ready=1.
REQ-021 A slot SHALL match when valid, base<=addr<=limit (unsigned, inclusive) and is_ispace==(chk_type==FETCH); the lowest-index match SHALL win.
REQ-022 No match SHALL give rsp_hit=0, allow=0, cause=NOMATCH.
REQ-023 With a hit, chk_user=1 and user_ok=0 SHALL give allow=0, cause=PRIV.
REQ-024 With a hit, a missing X (FETCH), R (LOAD) or W (STORE) bit SHALL give allow=0, cause=PERM; PRIV SHALL take precedence over PERM.
REQ-025 chk_type=3 SHALL give allow=0, cause=PERM.
REQ-026 A check in the same cycle as an accepted write SHALL use the pre-write table.
REQ-027 fault_cnt SHALL increment by 1 on each response handshake with allow=0 and SHALL saturate at 0xFFFF.

Reset
REQ-028 On rst_n low, asynchronously: region_valid=0, all slot fields=0, locked=0, prog_reject=0, rsp_valid=0, rsp_allow=0, rsp_hit=0, rsp_region=0, rsp_cause=NONE, fault_cnt=0.
REQ-029 An in-flight response SHALL be discarded at reset, and chk_ready SHALL be 1 after reset.

Structure
REQ-030 Package harvos_mpu_pkg SHALL hold the chk_type enum, the cause enum, the perm bit positions (R=0, W=1, X=2) and the region struct {base, limit, perm, user_ok, is_ispace}.
REQ-031 Sub-module mpu_region_match (combinational, one slot: match/perm/priv flags) SHALL be instantiated NREG times, with the priority encode kept in the parent.

Verification
REQ-032 Write slot0 0x0-0xFFFF RX ispace user_ok=1, slot1 0x2000_0000-0x2001_FFFF RW data, slot2 0x1000_0000-0x1000_FFFF RW user_ok=0, then lock_set -> region_valid=0b111, locked=1.
REQ-033 FETCH 0x0000_FFFF user -> allow=1, region=0; LOAD 0x0000_0100 -> allow=0, cause=NOMATCH (space mismatch); STORE 0x2001_FFFC -> allow=1, region=1.
REQ-034 LOAD 0x1000_0000 user=1 -> cause=PRIV; same request with user=0 -> allow=1, region=2; FETCH 0x2000_0000 -> cause=NOMATCH.
REQ-035 After lock, prog_en idx=3 -> prog_reject pulse and region_valid unchanged; pre-lock perm=3'b110 -> reject; base 0x100 with limit 0xFF -> reject; prog_en with lock_set in the same cycle -> reject and locked=1.
REQ-036 Hold rsp_ready=0 for 3 cycles with chk_valid=1 -> chk_ready=0 and response stable, with no request lost; back-to-back denies while fault_cnt preloaded to 0xFFFE -> saturates at 0xFFFF.
REQ-037 Assert rst_n low while rsp_valid=1 -> all outputs at reset values immediately, locked=0.
